usart_echo_8n1: RTL and testbench
=================================

Name: usart_echo_8n1

Overview:
UART 8N1 loopback block. It receives serial bytes on i_data at a fixed clocks-per-bit rate. Each correctly framed byte is retransmitted unchanged on o_data at the same rate. It sits directly at the board UART pins as a bring-up/echo demo.

Parameters:
CLKS_PER_BIT, 5, clock cycles per serial bit; legal range 4..65535.
DATA_BITS, 8, data bits per frame; fixed at 8, LSB first.

Ports:
i_clk  input  1  system clock, rising-edge active.
i_rst  input  1  asynchronous active-high reset.
i_data  input  1  serial RX line, idle high.
o_data  output  1  serial TX line, idle high.

Behaviour:
Reset:
- One clock domain. Asynchronous active-high reset acts immediately on assertion.
- While in reset: o_data=1; RX and TX FSMs in IDLE; counters cleared; synchroniser flops set to 1; holding buffer empty.
- Reset mid-frame aborts both RX and TX. o_data returns to 1 immediately.

RX input conditioning:
- i_data passes through a 2-flop synchroniser, reset value 1.
- The RX FSM uses only the synchronised signal (rx_s).

RX FSM states: IDLE, START, DATA, STOP.
- IDLE: a 1->0 transition on rx_s enters START; the bit counter is cleared.
- START: wait CLKS_PER_BIT/2 (integer division) cycles, then sample rx_s.
  - If 0: go to DATA.
  - If 1 (glitch): go back to IDLE.
- DATA: sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first, shifted into rx_shift. Then go to STOP.
- STOP: sample once CLKS_PER_BIT cycles later.
  - If 1: byte is valid; assert one-cycle rx_valid on the next cycle.
  - If 0 (framing error): byte is discarded and no rx_valid is produced. Go to IDLE and wait for rx_s to return high before arming for the next start edge.
  - Either way, return to IDLE immediately after the stop sample. Back-to-back frames with a one-bit stop are accepted.

Handoff (one-entry buffer):
- rx_valid with TX IDLE: byte loaded straight into TX.
- rx_valid with TX busy and buffer empty: byte stored in the buffer. TX takes it on its first IDLE cycle after the current stop bit.
- rx_valid with TX busy and buffer full: new byte dropped; buffered byte kept.

TX FSM states: IDLE, START, DATA, STOP.
- IDLE: o_data=1.
- On load: o_data=0 for CLKS_PER_BIT cycles (start bit).
- Then 8 data bits LSB first, each CLKS_PER_BIT cycles.
- Then o_data=1 for CLKS_PER_BIT cycles (stop bit), then IDLE.
- o_data is driven from a register (glitch-free).
- Latency: o_data falls on the 2nd rising edge after the RX stop-sample edge (rx_valid edge + 1) when TX was idle.

Widths and boundaries:
- Baud counter is ceil(log2(CLKS_PER_BIT)) bits and wraps to 0 at CLKS_PER_BIT-1.
- Bit counter is 3 bits; DATA exits after count 7.
- Line stuck low: no rx_valid is produced. Exactly one frame attempt is made, followed by a framing error. Re-arming requires rx_s high.
- An X/undriven i_data before the first valid high level is not supported. Benches must drive i_data high after reset.

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles, then i_data=1 for 100 cycles -> o_data=1 throughout, no TX activity.
- Single byte, CLKS_PER_BIT=5 (10 ns clock, 50 ns bits): send start 0, data 1,1,0,1,0,0,1,1, stop 1 (byte 0xCB) -> o_data shows start 0, bits 1,1,0,1,0,0,1,1, stop 1. Each bit lasts exactly 5 cycles; start edge occurs 2 cycles after the RX stop sample.
- Framing error: 0x55 with stop bit held 0 for one bit period, then line high -> o_data stays 1; a following valid 0xA5 frame is echoed correctly.
- Start glitch: i_data low for 1 cycle only -> no frame received, o_data stays 1.
- Back-to-back: 0x00, 0xFF, 0x3C sent with no idle gap -> all three echoed in order. Second byte is buffered; third arrives after the buffer has drained and is not dropped.
- Async reset mid-TX: assert i_rst during the 4th echoed data bit -> o_data=1 in the same cycle, both FSMs idle; the next frame is echoed normally.

Source files
------------

// File: rtl/usart_echo_8n1.sv
// usart_echo_8n1 - UART 8N1 loopback.
// Bytes received on i_data with a correct stop bit are sent back unchanged on
// o_data at the same bit rate. A one-entry buffer absorbs a byte that arrives
// while the transmitter is still busy; further bytes in that window are dropped.
// Ports:
//   i_clk  - system clock, rising edge
//   i_rst  - asynchronous active-high reset
//   i_data - serial RX line, idle high
//   o_data - serial TX line, idle high, registered
module usart_echo_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 5,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  output logic o_data
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // RX side
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  state_t               rx_state_q, rx_state_d;
  logic [BW-1:0]        rx_baud_q, rx_baud_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_valid_q, rx_valid_d;

  // TX side and handoff buffer
  state_t               tx_state_q, tx_state_d;
  logic [BW-1:0]        tx_baud_q, tx_baud_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic                 o_data_q, o_data_d;

  assign o_data = o_data_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_meta_q  <= i_data;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Arming needs a 1->0 edge on rx_s, so after a framing error (line still
  // low) nothing restarts until the line has been seen high again.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          rx_state_d = START;
          rx_baud_d  = '0;
          rx_bit_d   = '0;
        end
      end
      START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_state_d = rx_s_q ? IDLE : DATA;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_LAST) rx_state_d = STOP;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      STOP: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_valid_d = rx_s_q;
          rx_state_d = IDLE;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state_q <= IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      o_data_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      o_data_q   <= o_data_d;
    end
  end

  // A buffered byte is older than any byte arriving in the same cycle, so an
  // idle TX drains the buffer first and the new byte takes its place.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    case (tx_state_q)
      IDLE: begin
        if (buf_full_q) begin
          tx_state_d = START;
          tx_baud_d  = '0;
          tx_shift_d = buf_q;
          buf_full_d = rx_valid_q;
          if (rx_valid_q) buf_d = rx_shift_q;
        end else if (rx_valid_q) begin
          tx_state_d = START;
          tx_baud_d  = '0;
          tx_shift_d = rx_shift_q;
        end
      end
      START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == BIT_LAST) tx_state_d = STOP;
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      STOP: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_state_d = IDLE;
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
    if (tx_state_q != IDLE && rx_valid_q && !buf_full_q) begin
      buf_d      = rx_shift_q;
      buf_full_d = 1'b1;
    end
  end

  // Line level follows the current TX state one cycle later, so every bit
  // still lasts exactly CLKS_PER_BIT cycles and the pin is glitch-free.
  always_comb begin
    case (tx_state_q)
      START:   o_data_d = 1'b0;
      DATA:    o_data_d = tx_shift_q[0];
      default: o_data_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_usart_echo_8n1.sv
// Bench for usart_echo_8n1: drives serial frames, decodes the echoed line
// independently and compares against a queue of bytes that should be echoed.
module tb_usart_echo_8n1;

  localparam int CLKS = 5;

  logic clk, rst, rx_line, tx_line;

  usart_echo_8n1 #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_data(rx_line),
    .o_data(tx_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int exp_q[$];
  bit mon_en = 1'b1;
  bit mon_busy = 1'b0;
  bit lat_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Frame = start(0), 8 data bits LSB first, stop bit; each bit CLKS cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    logic [9:0] f;
    f = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = f[i];
      if (i == 0) start_cyc = cyc;
      repeat (CLKS) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic quiet(input string tag, input int n);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_line !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Independent decoder of the TX line: 50 samples per frame, one per cycle.
  initial begin
    logic prev_o;
    logic [49:0] smp;
    logic [7:0] got;
    int fall_cyc, exp_b, shape_ok;
    prev_o = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev_o === 1'b1 && tx_line === 1'b0) begin
        mon_busy = 1'b1;
        fall_cyc = cyc;
        smp[0] = tx_line;
        for (int k = 1; k < 50; k++) begin
          @(negedge clk);
          smp[k] = tx_line;
        end
        shape_ok = (smp[45] === 1'b1) ? 1 : 0;
        for (int w = 0; w < 10; w++)
          for (int s = 1; s < CLKS; s++)
            if (smp[w*CLKS+s] !== smp[w*CLKS]) shape_ok = 0;
        for (int j = 0; j < 8; j++) got[j] = smp[(j+1)*CLKS + 2];
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        check("echo_byte", int'(got), exp_b);
        check("echo_shape", shape_ok, 1);
        if (lat_pending) begin
          // sync 2 + edge detect 1 + half bit 2 + 8 bits + stop 45 + valid/TX load 2
          check("echo_latency", fall_cyc - start_cyc, 52);
          lat_pending = 1'b0;
        end
        mon_busy = 1'b0;
      end
      prev_o = tx_line;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d done", passed, total);
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] b;
    bit err;
    rst = 1'b1;
    rx_line = 1'b1;
    @(negedge clk);
    check("reset_odata", tx_line, 1);
    @(negedge clk);
    rst = 1'b0;
    quiet("idle_after_reset", 100);

    // Single byte with latency and bit-timing check
    exp_q.push_back(8'hCB);
    lat_pending = 1'b1;
    send_frame(8'hCB, 1'b1);
    drain("drain_single");
    check("latency_checked", int'(lat_pending), 0);
    idle(20);

    // Framing error then a valid frame
    send_frame(8'h55, 1'b0);
    rx_line = 1'b1;
    quiet("framing_err_quiet", 2*CLKS + 60);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    drain("drain_after_ferr");

    // One-cycle start glitch, then a stuck-low line
    rx_line = 1'b0;
    @(negedge clk);
    rx_line = 1'b1;
    quiet("start_glitch", 100);
    rx_line = 1'b0;
    quiet("stuck_low", 20*CLKS);
    rx_line = 1'b1;
    quiet("after_stuck_low", 100);

    // Back-to-back frames, no idle gap
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    drain("drain_b2b");
    idle(10);

    // Random traffic; gaps keep the buffer from overflowing, so every
    // well-framed byte must come back in order.
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      err = ($urandom_range(0, 5) == 0);
      if (!err) exp_q.push_back(int'(b));
      send_frame(b, !err);
      idle(err ? CLKS + int'($urandom_range(0, 10)) : int'($urandom_range(0, 10)));
    end
    drain("drain_random");
    idle(10);

    // Asynchronous reset in the middle of the 4th echoed data bit
    mon_en = 1'b0;
    send_frame(8'hC3, 1'b1);
    n = 0;
    while (tx_line !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", tx_line, 0);
    repeat (3*CLKS + CLKS + 2) @(negedge clk);
    check("data_bit3_before_rst", tx_line, 0);
    #2 rst = 1'b1;
    #1 check("rst_async_odata", tx_line, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet("idle_after_mid_rst", 80);
    mon_en = 1'b1;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    drain("drain_after_rst");
    idle(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
